// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control blocks:
// register-specifier width, the zero register and the hazard FSM state type.
package mips_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        NOHAZARD = 2'b00,
        JUMP     = 2'b01,
        BRANCH_0 = 2'b10,
        BRANCH_1 = 2'b11
    } hazard_state_t;

    // Pipeline steering bundle driven by the hazard unit each cycle.
    typedef struct packed {
        logic pc_write;
        logic if_write;
        logic bubble;
        logic addr_sel;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t CTRL_RUN   = '{pc_write: 1'b1, if_write: 1'b1, bubble: 1'b0, addr_sel: 1'b0};
    localparam hazard_ctrl_t CTRL_STALL = '{pc_write: 1'b0, if_write: 1'b0, bubble: 1'b1, addr_sel: 1'b0};

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use compare: a load in EX whose destination feeds a
// source operand of the instruction in ID cannot be covered by forwarding.
module load_use_detector
    import mips_pipe_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_use_rt,
    input  logic [ADDR_W-1:0] ex_rw,
    input  logic              ex_mem_read,
    output logic              load_use
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (id_rs == ex_rw);
    assign rt_match = id_use_rt && (id_rt == ex_rw);

    // $zero is never really written, so a load targeting it never stalls.
    assign load_use = ex_mem_read && (ex_rw != ADDR_W'(REG_ZERO)) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller: one bubble per load-use, jump/branch penalty sequencing.
// Optional load-use stall counter enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_detection_unit
    import mips_pipe_pkg::*;
#(
    parameter int REG_ADDR_W  = mips_pipe_pkg::REG_ADDR_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [REG_ADDR_W-1:0]  ID_Rs,
    input  logic [REG_ADDR_W-1:0]  ID_Rt,
    input  logic                   ID_UseRt,
    input  logic                   ID_Jump,
    input  logic                   ID_Branch,
    input  logic [REG_ADDR_W-1:0]  EX_Rw,
    input  logic                   EX_MemRead,
    input  logic                   EX_BranchTaken,
    output logic                   PCWrite,
    output logic                   IFWrite,
    output logic                   Bubble,
    output logic                   AddrSel,
    output logic [STALL_CNT_W-1:0] StallCount
);

    hazard_state_t state;
    hazard_state_t state_next;
    hazard_ctrl_t  ctrl;
    logic          load_use;

    load_use_detector #(.ADDR_W(REG_ADDR_W)) u_load_use (
        .id_rs       (ID_Rs),
        .id_rt       (ID_Rt),
        .id_use_rt   (ID_UseRt),
        .ex_rw       (EX_Rw),
        .ex_mem_read (EX_MemRead),
        .load_use    (load_use)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= NOHAZARD;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_next = NOHAZARD;
        ctrl       = CTRL_RUN;
        case (state)
            NOHAZARD: begin
                state_next = NOHAZARD;
                if (load_use) begin
                    ctrl = CTRL_STALL;
                end else if (ID_Jump) begin
                    ctrl       = '{pc_write: 1'b1, if_write: 1'b0, bubble: 1'b0, addr_sel: 1'b0};
                    state_next = JUMP;
                end else if (ID_Branch) begin
                    ctrl       = '{pc_write: 1'b0, if_write: 1'b0, bubble: 1'b0, addr_sel: 1'b0};
                    state_next = BRANCH_0;
                end
            end
            JUMP: begin
                ctrl = '{pc_write: 1'b1, if_write: 1'b1, bubble: 1'b1, addr_sel: 1'b0};
            end
            BRANCH_0: begin
                if (EX_BranchTaken) begin
                    ctrl       = '{pc_write: 1'b1, if_write: 1'b0, bubble: 1'b1, addr_sel: 1'b1};
                    state_next = BRANCH_1;
                end else begin
                    ctrl = '{pc_write: 1'b1, if_write: 1'b1, bubble: 1'b1, addr_sel: 1'b0};
                end
            end
            BRANCH_1: begin
                ctrl = '{pc_write: 1'b1, if_write: 1'b1, bubble: 1'b1, addr_sel: 1'b0};
            end
            default: begin
                ctrl = CTRL_RUN;
            end
        endcase
        // Reset freezes fetch and feeds nops regardless of the registered state.
        if (Reset) ctrl = CTRL_STALL;
    end

    assign PCWrite = ctrl.pc_write;
    assign IFWrite = ctrl.if_write;
    assign Bubble  = ctrl.bubble;
    assign AddrSel = ctrl.addr_sel;

`ifdef HAZARD_STALL_COUNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stall_cnt <= '0;
        end else if ((state == NOHAZARD) && load_use && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit; expected outputs are hand-derived.
// Output vector order is {PCWrite, IFWrite, Bubble, AddrSel}.
module tb_hazard_detection_unit;

    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 16;
`ifdef HAZARD_STALL_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic                   CLK = 1'b0;
    logic                   Reset;
    logic [REG_ADDR_W-1:0]  ID_Rs, ID_Rt, EX_Rw;
    logic                   ID_UseRt, ID_Jump, ID_Branch, EX_MemRead, EX_BranchTaken;
    logic                   PCWrite, IFWrite, Bubble, AddrSel;
    logic [STALL_CNT_W-1:0] StallCount;

    int tests_run = 0;
    int tests_failed = 0;

    hazard_detection_unit #(.REG_ADDR_W(REG_ADDR_W), .STALL_CNT_W(STALL_CNT_W)) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UseRt       (ID_UseRt),
        .ID_Jump        (ID_Jump),
        .ID_Branch      (ID_Branch),
        .EX_Rw          (EX_Rw),
        .EX_MemRead     (EX_MemRead),
        .EX_BranchTaken (EX_BranchTaken),
        .PCWrite        (PCWrite),
        .IFWrite        (IFWrite),
        .Bubble         (Bubble),
        .AddrSel        (AddrSel),
        .StallCount     (StallCount)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Let combinational outputs settle, then compare the control vector.
    task automatic check_ctrl(input string tag, input logic [3:0] expected);
        #2;
        check(tag, {28'd0, PCWrite, IFWrite, Bubble, AddrSel}, {28'd0, expected});
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ID_Rs = 5'd1; ID_Rt = 5'd2; ID_UseRt = 1'b0;
        ID_Jump = 1'b0; ID_Branch = 1'b0;
        EX_Rw = 5'd3; EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        next_cycle();
        check_ctrl("reset_ctrl", 4'b0010);
        check("reset_cnt", 32'(StallCount), 32'd0);

        Reset = 1'b0;
        check_ctrl("idle", 4'b1100);

        // Load-use on Rs: exactly one bubble.
        next_cycle();
        EX_MemRead = 1'b1; EX_Rw = 5'd8; ID_Rs = 5'd8;
        check_ctrl("lu_rs_stall", 4'b0010);
        next_cycle();
        EX_MemRead = 1'b0;
        check_ctrl("lu_rs_resume", 4'b1100);
        check("lu_cnt1", 32'(StallCount), 32'(CNT_EN * 1));

        // Zero-register and Rt gating.
        next_cycle();
        EX_MemRead = 1'b1; EX_Rw = 5'd0; ID_Rs = 5'd0;
        check_ctrl("lu_zero_reg", 4'b1100);
        next_cycle();
        EX_Rw = 5'd9; ID_Rs = 5'd1; ID_Rt = 5'd9; ID_UseRt = 1'b0;
        check_ctrl("lu_rt_unused", 4'b1100);
        ID_UseRt = 1'b1;
        check_ctrl("lu_rt_used", 4'b0010);
        next_cycle();
        idle_inputs();
        check_ctrl("lu_rt_resume", 4'b1100);

        // Jump: 1 cycle penalty; ID inputs ignored in JUMP.
        next_cycle();
        ID_Jump = 1'b1;
        check_ctrl("jump_id", 4'b1000);
        next_cycle();
        ID_Branch = 1'b1; EX_MemRead = 1'b1; EX_Rw = 5'd1;
        check_ctrl("jump_squash", 4'b1110);
        next_cycle();
        idle_inputs();
        check_ctrl("jump_done", 4'b1100);

        // Taken branch: 3 cycles.
        next_cycle();
        ID_Branch = 1'b1;
        check_ctrl("br_t_id", 4'b0000);
        next_cycle();
        ID_Branch = 1'b0; EX_BranchTaken = 1'b1;
        check_ctrl("br_t_ex", 4'b1011);
        next_cycle();
        EX_BranchTaken = 1'b0;
        check_ctrl("br_t_b1", 4'b1110);
        next_cycle();
        check_ctrl("br_t_done", 4'b1100);

        // Not-taken branch, then back-to-back jump and branch.
        next_cycle();
        ID_Branch = 1'b1;
        check_ctrl("br_nt_id", 4'b0000);
        next_cycle();
        ID_Branch = 1'b0;
        check_ctrl("br_nt_ex", 4'b1110);
        next_cycle();
        ID_Jump = 1'b1;
        check_ctrl("b2b_jump_id", 4'b1000);
        next_cycle();
        ID_Jump = 1'b0;
        check_ctrl("b2b_jump_sq", 4'b1110);
        next_cycle();
        ID_Branch = 1'b1;
        check_ctrl("b2b_br_id", 4'b0000);
        next_cycle();
        ID_Branch = 1'b0;
        check_ctrl("b2b_br_ex", 4'b1110);
        next_cycle();
        check_ctrl("b2b_done", 4'b1100);

        // Jump and branch together: jump wins (taken=1 would expose BRANCH_0).
        next_cycle();
        ID_Jump = 1'b1; ID_Branch = 1'b1;
        check_ctrl("jb_both_id", 4'b1000);
        next_cycle();
        ID_Jump = 1'b0; ID_Branch = 1'b0; EX_BranchTaken = 1'b1;
        check_ctrl("jb_both_next", 4'b1110);
        next_cycle();
        idle_inputs();

        // Load-use has priority over jump.
        EX_MemRead = 1'b1; EX_Rw = 5'd4; ID_Rs = 5'd4; ID_Jump = 1'b1;
        check_ctrl("prio_stall", 4'b0010);
        next_cycle();
        EX_MemRead = 1'b0;
        check_ctrl("prio_jump_id", 4'b1000);
        next_cycle();
        ID_Jump = 1'b0;
        check_ctrl("prio_jump_sq", 4'b1110);
        next_cycle();
        check_ctrl("prio_done", 4'b1100);
        check("cnt_total", 32'(StallCount), 32'(CNT_EN * 3));

        // Reset in BRANCH_0 acts immediately; release lands in NOHAZARD.
        next_cycle();
        ID_Branch = 1'b1;
        check_ctrl("rst_br_id", 4'b0000);
        next_cycle();
        ID_Branch = 1'b0; EX_BranchTaken = 1'b1;
        check_ctrl("rst_br_ex", 4'b1011);
        Reset = 1'b1;
        check_ctrl("rst_async", 4'b0010);
        check("rst_cnt", 32'(StallCount), 32'd0);
        next_cycle();
        Reset = 1'b0;
        check_ctrl("rst_release", 4'b1100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Stall and flush controller for the 5-stage MIPS pipeline. It is the producer-side counterpart to operand forwarding.
- Detects load-use hazards that forwarding cannot resolve and inserts one bubble for each.
- Sequences the control-hazard penalty for jumps (resolved in ID) and branches (resolved in EX).
- Drives the PC write enable, the IF/ID write enable, the ID/EX bubble select and the PC address select.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- STALL_CNT_W, 16, width of the stall counter (used only under the optional feature).

Ports:
- CLK  input  1  pipeline clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- ID_Rs  input  REG_ADDR_W  source register Rs of the instruction in ID.
- ID_Rt  input  REG_ADDR_W  source register Rt of the instruction in ID.
- ID_UseRt  input  1  instruction in ID reads Rt as a source (R-type, store, branch).
- ID_Jump  input  1  instruction in ID is j/jal/jr.
- ID_Branch  input  1  instruction in ID is a conditional branch.
- EX_Rw  input  REG_ADDR_W  destination register of the instruction in EX (after the Rd/Rt mux).
- EX_MemRead  input  1  instruction in EX is a load.
- EX_BranchTaken  input  1  branch in EX resolved taken (valid in BRANCH_0).
- PCWrite  output  1  PC register load enable.
- IFWrite  output  1  IF/ID register load enable; 0 holds or squashes.
- Bubble  output  1  ID/EX takes zeroed control (nop).
- AddrSel  output  1  0 = PC+4 or jump target path; 1 = branch target.
- StallCount  output  STALL_CNT_W  load-use stall count (optional feature).

Behaviour:
- Reset is asynchronous and active-high. While Reset=1:
  - state = NOHAZARD.
  - PCWrite=0, IFWrite=0, Bubble=1, AddrSel=0.
  - StallCount=0.
- Outputs are Mealy: combinational from the state and current inputs. The state register updates on the rising edge of CLK.
- LoadUse = EX_MemRead & (EX_Rw != 0) & ((ID_Rs == EX_Rw) | (ID_UseRt & ID_Rt == EX_Rw)).
- State NOHAZARD, checked in priority order:
  - LoadUse: PCWrite=0, IFWrite=0, Bubble=1, AddrSel=0; next NOHAZARD. This is exactly one bubble per load-use; the same instruction re-evaluates the next cycle. LoadUse takes priority over ID_Jump and ID_Branch.
  - ID_Jump: PCWrite=1, IFWrite=0, Bubble=0, AddrSel=0; next JUMP.
  - ID_Branch: PCWrite=0, IFWrite=0, Bubble=0, AddrSel=0; next BRANCH_0.
  - Otherwise: PCWrite=1, IFWrite=1, Bubble=0, AddrSel=0; stay.
- State JUMP:
  - PCWrite=1, IFWrite=1, Bubble=1, AddrSel=0. The squashed fetch slot becomes a nop.
  - Next NOHAZARD. ID inputs are ignored in this state.
- State BRANCH_0 (branch now in EX):
  - EX_BranchTaken=1: PCWrite=1, IFWrite=0, Bubble=1, AddrSel=1; next BRANCH_1.
  - EX_BranchTaken=0: PCWrite=1, IFWrite=1, Bubble=1, AddrSel=0; next NOHAZARD.
- State BRANCH_1:
  - PCWrite=1, IFWrite=1, Bubble=1, AddrSel=0; next NOHAZARD.
- Penalties:
  - Jump: 1 cycle.
  - Not-taken branch: 2 cycles.
  - Taken branch: 3 cycles.
  - Load-use: 1 cycle.
- Boundary conditions:
  - Back-to-back jump or branch after returning to NOHAZARD is evaluated normally with no extra cycle.
  - EX_Rw=0 never causes a stall.
  - ID_Jump and ID_Branch both asserted: ID_Jump wins.
  - Reset asserted in any state forces NOHAZARD immediately. Release takes effect at the next CLK edge.
- The state encoding is 2-bit. Unreachable encodings go to NOHAZARD with the NOHAZARD "otherwise" outputs.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- Defined:
  - StallCount increments by 1 on each CLK edge where the state is NOHAZARD and LoadUse=1.
  - It saturates at all-ones and is cleared by Reset.
- Undefined: StallCount is tied to 0 and no counter flops exist.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - REG_ADDR_W.
  - The hazard state enum hazard_state_t {NOHAZARD, JUMP, BRANCH_0, BRANCH_1}.
  - The REG_ZERO constant.
- One natural sub-module: load_use_detector, the combinational LoadUse compare. It is instantiated once.

Test Plan:
- Load-use stall: EX_MemRead=1, EX_Rw=8, ID_Rs=8 -> one cycle with PCWrite=0, IFWrite=0, Bubble=1. Next cycle, with EX_MemRead=0, outputs are 1/1/0 and StallCount=1.
- Zero-register and Rt gating:
  - EX_MemRead=1, EX_Rw=0, ID_Rs=0 -> no stall.
  - EX_Rw=9, ID_Rt=9, ID_UseRt=0 -> no stall.
  - Same with ID_UseRt=1 -> stall.
- Jump: ID_Jump=1 -> NOHAZARD cycle gives PCWrite=1, IFWrite=0, Bubble=0; the JUMP cycle gives 1/1/1. Total 2 cycles, then NOHAZARD.
- Taken branch: ID_Branch=1, then EX_BranchTaken=1 -> three cycles:
  - (PCWrite,IFWrite,Bubble,AddrSel) = 0,0,0,0.
  - Then 1,0,1,1.
  - Then 1,1,1,0.
  - Then back to NOHAZARD.
- Not-taken branch: ID_Branch=1, then EX_BranchTaken=0 -> two cycles, 0,0,0,0 then 1,1,1,0, then NOHAZARD.
- Priority and reset:
  - LoadUse=1 with ID_Jump=1 -> stall first, then the jump sequence.
  - Reset asserted mid-BRANCH_0 -> outputs immediately 0,0,1,0. After release, the state is NOHAZARD.
